// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage owning the PC and a req/ack instruction memory port.
//
// Ports:
//   i_Clock       - clock, rising edge
//   i_Reset       - asynchronous active-low reset
//   i_PCNextSel   - next-PC select: 00 PC+4, 01 PC+offset, 10 rs1+offset, 11 as 00
//   i_Offset      - sign-extended immediate of the held instruction
//   i_RegBase     - rs1 value for indirect jumps
//   i_Retire      - datapath finished the held instruction
//   o_IMemReq     - registered instruction read request
//   o_IMemAddr    - read address (always the PC)
//   i_IMemAck     - read data valid this cycle
//   i_IMemData    - instruction word
//   o_Inst        - held instruction (NOP_INST when none is held)
//   o_InstValid   - o_Inst holds a fetched instruction
//   o_PC          - PC of the held or requested instruction
//   o_PCPlus4     - o_PC + 4 for link writeback
//   o_Misaligned  - misaligned target trap (only with FETCH_MISALIGN_TRAP_EN)
//
// Build option FETCH_MISALIGN_TRAP_EN: a misaligned target halts the unit until
// reset; without it the low two target bits are cleared and fetch continues.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic [1:0]  i_PCNextSel,
    input  logic [31:0] i_Offset,
    input  logic [31:0] i_RegBase,
    input  logic        i_Retire,
    output logic        o_IMemReq,
    output logic [31:0] o_IMemAddr,
    input  logic        i_IMemAck,
    input  logic [31:0] i_IMemData,
    output logic [31:0] o_Inst,
    output logic        o_InstValid,
    output logic [31:0] o_PC,
    output logic [31:0] o_PCPlus4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        o_Misaligned
`endif
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
`endif

    state_t      state;
    logic [31:0] target;

    // Reserved select 11 falls through to PC+4; JALR clears bit 0 of its target.
    always_comb
        target = (i_PCNextSel == 2'b01) ? o_PC + i_Offset :
                 (i_PCNextSel == 2'b10) ? (i_RegBase + i_Offset) & ~32'h1 :
                 o_PC + 32'd4;

    assign o_IMemAddr = o_PC;
    assign o_PCPlus4  = o_PC + 32'd4;

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state       <= IDLE;
            o_PC        <= RESET_PC;
            o_Inst      <= NOP_INST;
            o_InstValid <= 1'b0;
            o_IMemReq   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            o_Misaligned <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state     <= FETCH;
                    o_IMemReq <= 1'b1;
                end
                FETCH: if (i_IMemAck) begin
                    o_Inst      <= i_IMemData;
                    o_InstValid <= 1'b1;
                    o_IMemReq   <= 1'b0;
                    state       <= EXEC;
                end
                EXEC: if (i_Retire) begin
                    o_Inst      <= NOP_INST;
                    o_InstValid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                    // The faulting target is still loaded so it is visible on o_PC.
                    o_PC <= target;
                    if (|target[1:0]) begin
                        state        <= HALT;
                        o_Misaligned <= 1'b1;
                        o_IMemReq    <= 1'b0;
                    end else begin
                        state     <= FETCH;
                        o_IMemReq <= 1'b1;
                    end
`else
                    o_PC      <= target & ~32'h3;
                    state     <= FETCH;
                    o_IMemReq <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
